// File: rtl/hash_target_filter_pkg.sv
// Shared constants for the SHA-256 hash target filter.
// Hash width and default sizing used by the other SHA-256 blocks.
package hash_target_filter_pkg;

  localparam int HASH_W     = 256;
  localparam int DEPTH_DEF  = 8;
  localparam int TAG_W_DEF  = 32;
  localparam int DROP_W_DEF = 16;

endpackage

// File: rtl/hash_target_filter_if.sv
// Result stream from the target filter to the host.
// Show-ahead valid/ready with hash and sequence tag.
interface hash_target_filter_if
  import hash_target_filter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);

  logic [HASH_W-1:0] out_hash;
  logic [TAG_W-1:0]  out_tag;
  logic              out_vld;
  logic              out_rdy;

  modport master (
    output out_hash,
    output out_tag,
    output out_vld,
    input  out_rdy
  );

  modport slave (
    input  out_hash,
    input  out_tag,
    input  out_vld,
    output out_rdy
  );

endinterface

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO, async reset plus sync clear.
// A write into a full FIFO is accepted only alongside a read.
module sync_fifo_sa #(
  parameter int WIDTH = 288,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (wr_ok && !clr)
      mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr_ok)
        wp <= wp + AW'(1);
      if (rd_ok)
        rp <= rp + AW'(1);
      if (wr_ok && !rd_ok)
        level <= level + (AW+1)'(1);
      else if (rd_ok && !wr_ok)
        level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hash_target_filter.sv
// Tags each hash, keeps those strictly below target in a FIFO.
// Never stalls the hash core; hits lost to a full FIFO are counted.
module hash_target_filter
  import hash_target_filter_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HASH_W-1:0]      target,
  input  logic                   target_wr,
  input  logic                   clr,
  input  logic [HASH_W-1:0]      in_hash,
  input  logic                   in_vld,
  hash_target_filter_if.master   out_if,
  output logic [TAG_W-1:0]       hash_cnt,
  output logic [TAG_W-1:0]       hit_cnt,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int W = TAG_W + HASH_W;

  logic [HASH_W-1:0] tgt_q;
  logic [HASH_W-1:0] s1_hash;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_vld;
  logic              hit;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [W-1:0]      rd_data;

  assign hit  = s1_vld && (s1_hash < tgt_q);
  assign pop  = out_if.out_vld && out_if.out_rdy;
  assign drop = hit && full && !pop;

  assign out_if.out_vld = !empty;
  assign {out_if.out_tag, out_if.out_hash} = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tgt_q <= '0;
    else if (target_wr)
      tgt_q <= target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_hash  <= '0;
      s1_tag   <= '0;
      hash_cnt <= '0;
    end else if (clr) begin
      s1_vld   <= 1'b0;
      hash_cnt <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_hash  <= in_hash;
        s1_tag   <= hash_cnt;
        hash_cnt <= hash_cnt + TAG_W'(1);
      end
    end
  end

  // hit_cnt includes hits the FIFO had no room for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      hit_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (hit)
        hit_cnt <= hit_cnt + TAG_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  sync_fifo_sa #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (hit),
    .wr_data ({s1_tag, s1_hash}),
    .rd_en   (out_if.out_rdy),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_hash_target_filter.sv
// Bench for hash_target_filter: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hash_target_filter;
  import hash_target_filter_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [HASH_W-1:0] target = '0;
  logic              target_wr = 1'b0;
  logic              clr = 1'b0;
  logic [HASH_W-1:0] in_hash = '0;
  logic              in_vld = 1'b0;
  logic [31:0]       hash_cnt;
  logic [31:0]       hit_cnt;
  logic [15:0]       drop_cnt;
  logic              overflow;
  logic [3:0]        fifo_level;

  hash_target_filter_if out_if();

  hash_target_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .target     (target),
    .target_wr  (target_wr),
    .clr        (clr),
    .in_hash    (in_hash),
    .in_vld     (in_vld),
    .out_if     (out_if),
    .hash_cnt   (hash_cnt),
    .hit_cnt    (hit_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", nm, got, exp);
  endfunction

  typedef struct {
    logic [31:0]  tag;
    logic [255:0] h;
  } ent_t;

  ent_t         q[$];
  logic [255:0] m_tgt;
  logic [255:0] m_ph;
  logic [31:0]  m_pt;
  bit           m_pv;
  logic [31:0]  m_hc;
  logic [31:0]  m_hit;
  int           m_drop;
  bit           m_ovf;
  int           m_before;
  bit           m_pop;
  bit           m_h;
  bit           saw_vld;

  // Behavioural model: one hash per edge, queue of kept results
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_tgt = '0; m_pv = 0; m_hc = 0;
      m_hit = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (clr) begin
        q.delete();
        m_pv = 0; m_hc = 0; m_hit = 0;
        m_drop = 0; m_ovf = 0;
      end else begin
        m_before = q.size();
        m_pop = (m_before > 0) && out_if.out_rdy;
        m_h = m_pv && (m_ph < m_tgt);
        if (m_pop) void'(q.pop_front());
        if (m_h) begin
          m_hit = m_hit + 1;
          if (m_before == 8 && !m_pop) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
          end else begin
            q.push_back('{tag: m_pt, h: m_ph});
          end
        end
        m_pv = in_vld;
        if (in_vld) begin
          m_ph = in_hash;
          m_pt = m_hc;
          m_hc = m_hc + 1;
        end
      end
      if (target_wr) m_tgt = target;
    end
  end

  always @(negedge clk) begin
    if (out_if.out_vld) saw_vld = 1;
    chk("out_vld", out_if.out_vld, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("hash_cnt", hash_cnt, m_hc);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", overflow, m_ovf);
    if (q.size() != 0) begin
      chk("out_hash", out_if.out_hash, q[0].h);
      chk("out_tag", out_if.out_tag, q[0].tag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] t240;
  logic [31:0]  exp_t;

  initial begin
    out_if.out_rdy = 1'b0;
    t240 = 256'd1 << 240;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_hash_cnt", hash_cnt, 0);
    chk("rst_out_vld", out_if.out_vld, 0);
    chk("rst_level", fifo_level, 0);

    // 1: target 0 never hits
    saw_vld = 0;
    target = '0; target_wr = 1;
    for (int i = 0; i < 10; i++) begin
      in_vld = 1;
      in_hash = (i == 0) ? 256'd0 : {8'(i), 248'd0};
      step();
      target_wr = 0;
    end
    in_vld = 0;
    step(); step();
    chk("t1_hash_cnt", hash_cnt, 10);
    chk("t1_hit_cnt", hit_cnt, 0);
    chk("t1_never_vld", saw_vld, 0);

    // 2: strict compare at 2^240, latency 2
    clr = 1; target = t240; target_wr = 1;
    step();
    clr = 0; target_wr = 0;
    in_vld = 1; in_hash = t240 - 1;
    step();
    chk("t2_vld_e0", out_if.out_vld, 0);
    in_hash = t240;
    step();
    chk("t2_vld_e1", out_if.out_vld, 1);
    chk("t2_tag", out_if.out_tag, 0);
    chk("t2_hash", out_if.out_hash, t240 - 1);
    in_vld = 0;
    step(); step();
    chk("t2_hit_cnt", hit_cnt, 1);
    chk("t2_level", fifo_level, 1);

    // 3: overflow with 10 hits into 8 slots
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 10; i++) begin
      in_vld = 1; in_hash = 256'(i + 1);
      step();
    end
    in_vld = 0;
    step(); step();
    chk("t3_level", fifo_level, 8);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_ovf", overflow, 1);
    chk("t3_hits", hit_cnt, 10);
    out_if.out_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_tag", out_if.out_tag, i);
      step();
    end
    chk("t3_empty", out_if.out_vld, 0);
    out_if.out_rdy = 0;

    // 4: full FIFO, push and pop every edge
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 9; i++) begin
      in_vld = 1; in_hash = 256'(i + 100);
      step();
    end
    chk("t4_full", fifo_level, 8);
    out_if.out_rdy = 1;
    exp_t = 0;
    for (int i = 0; i < 20; i++) begin
      in_vld = 1; in_hash = 256'(i + 200);
      chk("t4_tag", out_if.out_tag, exp_t);
      exp_t++;
      step();
      chk("t4_level", fifo_level, 8);
    end
    in_vld = 0;
    chk("t4_drop", drop_cnt, 0);
    out_if.out_rdy = 0;

    // 5: clr coincident with an input
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1; in_hash = 256'(i * 3);
      step();
    end
    clr = 1; in_hash = 256'd7;
    step();
    clr = 0;
    chk("t5_hash_cnt", hash_cnt, 0);
    chk("t5_hit_cnt", hit_cnt, 0);
    chk("t5_vld", out_if.out_vld, 0);
    in_hash = 256'd5;
    step();
    in_vld = 0;
    step();
    chk("t5_tag", out_if.out_tag, 0);
    chk("t5_hash", out_if.out_hash, 5);
    chk("t5_level", fifo_level, 1);
    chk("t5_hash_cnt2", hash_cnt, 1);

    // 6: async reset mid-drain
    for (int i = 0; i < 3; i++) begin
      in_vld = 1; in_hash = 256'(i + 50);
      step();
    end
    in_vld = 0;
    step();
    out_if.out_rdy = 1;
    step();
    #1 rst_n = 0;
    #1;
    chk("t6_vld", out_if.out_vld, 0);
    chk("t6_hash_cnt", hash_cnt, 0);
    chk("t6_hit_cnt", hit_cnt, 0);
    chk("t6_level", fifo_level, 0);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1; in_hash = 256'(i);
      step();
    end
    in_vld = 0;
    step(); step();
    chk("t6_post_hash_cnt", hash_cnt, 4);
    chk("t6_post_hits", hit_cnt, 0);
    chk("t6_post_vld", out_if.out_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
